// File: rtl/sw_rr_if.sv
// ---------------------------------------------------------------------------
// sw_rr_if -- flit bus between the port interfaces and the sw_rr switch.
//
// Optional feature macro: SW_PKTCNT_EN (adds the per-output packet counters).
//
// Signals
//   idata   NPORT*FLITW  input flit per port, port p at [p*FLITW +: FLITW]
//   iready  NPORT        port p input FIFO can accept a flit this cycle
//   odata   NPORT*FLITW  registered output flit per port
//   pkt_cnt NPORT*16     tails forwarded per output (SW_PKTCNT_EN only)
//
// Modports
//   master  port-interface side: drives idata, observes the rest
//   slave   switch side: consumes idata, drives iready/odata/pkt_cnt
// ---------------------------------------------------------------------------
interface sw_rr_if #(
    parameter int NPORT = 4,
    parameter int FLITW = 10
);
    logic [NPORT*FLITW-1:0] idata;
    logic [NPORT-1:0]       iready;
    logic [NPORT*FLITW-1:0] odata;
`ifdef SW_PKTCNT_EN
    logic [NPORT*16-1:0]    pkt_cnt;

    modport master (output idata, input iready, input odata, input pkt_cnt);
    modport slave  (input idata, output iready, output odata, output pkt_cnt);
`else
    modport master (output idata, input iready, input odata);
    modport slave  (input idata, output iready, output odata);
`endif
endinterface

// File: rtl/sw_rr.sv
// ---------------------------------------------------------------------------
// sw_rr -- parametrised wormhole packet switch, NPORT inputs x NPORT outputs.
//
// Every input has a DEPTH-flit FIFO. Every output runs a round-robin arbiter
// over the inputs whose FIFO front is a head addressed to it; the winner keeps
// the output from head to tail, one flit per cycle.
//
// Optional feature macro: SW_PKTCNT_EN -> per-output 16-bit tail counters on
// bus.pkt_cnt. Without it the counters and the port are absent.
//
// Parameters
//   NPORT  number of input and output ports (2..16)
//   FLITW  flit width; [FLITW-1:FLITW-2] = type, [FLITW-3:0] = payload
//   DEPTH  input FIFO depth in flits (power of two, >= 2)
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous reset, active high
//   bus   sw_rr_if.slave: idata in, iready/odata(/pkt_cnt) out
// ---------------------------------------------------------------------------
module sw_rr #(
    parameter int NPORT = 4,
    parameter int FLITW = 10,
    parameter int DEPTH = 4
) (
    input logic    clk,
    input logic    rst,
    sw_rr_if.slave bus
);
    localparam int SRCW = $clog2(NPORT);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    typedef logic [FLITW-1:0] flit_t;
    typedef enum logic [1:0] {
        FT_IDLE = 2'b00,
        FT_BODY = 2'b01,
        FT_HEAD = 2'b10,
        FT_TAIL = 2'b11
    } ftype_e;

    function automatic ftype_e ftype(input flit_t f);
        return ftype_e'(f[FLITW-1 -: 2]);
    endfunction

    // Destinations >= NPORT only exist when NPORT is not a power of two.
    function automatic logic dest_ok(input flit_t f);
        return int'(f[SRCW-1:0]) < NPORT;
    endfunction

    // Registered state
    flit_t            mem_q     [NPORT][DEPTH];
    logic [PTRW-1:0]  rd_ptr_q  [NPORT];
    logic [PTRW-1:0]  wr_ptr_q  [NPORT];
    logic [CNTW-1:0]  cnt_q     [NPORT];
    logic [NPORT-1:0] gnt_vld_q, gnt_vld_d;
    logic [SRCW-1:0]  gnt_src_q [NPORT];
    logic [SRCW-1:0]  gnt_src_d [NPORT];
    logic [SRCW-1:0]  rr_q      [NPORT];
    logic [SRCW-1:0]  rr_d      [NPORT];
    flit_t            odata_q   [NPORT];
    flit_t            odata_d   [NPORT];

    // Combinational helpers
    flit_t            in_flit   [NPORT];
    flit_t            front     [NPORT];
    logic [NPORT-1:0] nonempty;
    logic [NPORT-1:0] busy;      // input currently owns an output
    logic [NPORT-1:0] push;
    logic [NPORT-1:0] pop;
    logic [NPORT-1:0] tail_out;  // output o forwards a tail this cycle
    logic [SRCW-1:0]  idx;

    // Input side: FIFO push/pop decisions.
    // NOTE: every always_comb output gets a value before any condition, so no
    // path through the block can leave a signal holding its old value (latch).
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            in_flit[i]  = bus.idata[i*FLITW +: FLITW];
            front[i]    = mem_q[i][rd_ptr_q[i]];
            nonempty[i] = (cnt_q[i] != '0);
            push[i]     = (cnt_q[i] != CNTW'(DEPTH)) && (ftype(in_flit[i]) != FT_IDLE);
            busy[i]     = 1'b0;
            for (int o = 0; o < NPORT; o++) begin
                if (gnt_vld_q[o] && (gnt_src_q[o] == SRCW'(i))) busy[i] = 1'b1;
            end
            // A granted input streams its front out. An ungranted input whose
            // front is not a routable head can never win, so it is discarded;
            // this also drains the rest of a packet whose head had a bad dest.
            pop[i] = nonempty[i] &&
                     (busy[i] || (ftype(front[i]) != FT_HEAD) || !dest_ok(front[i]));
        end
    end

    // Output side: forwarding, grant release and round-robin arbitration.
    always_comb begin
        gnt_vld_d = gnt_vld_q;
        tail_out  = '0;
        idx       = '0;
        for (int o = 0; o < NPORT; o++) begin
            gnt_src_d[o] = gnt_src_q[o];
            rr_d[o]      = rr_q[o];
            odata_d[o]   = '0;
        end
        for (int o = 0; o < NPORT; o++) begin
            if (gnt_vld_q[o]) begin
                for (int i = 0; i < NPORT; i++) begin
                    if ((gnt_src_q[o] == SRCW'(i)) && nonempty[i]) begin
                        odata_d[o] = front[i];
                        // Release on the tail pop; the output is re-arbitrated
                        // next cycle, which leaves one idle flit between packets.
                        if (ftype(front[i]) == FT_TAIL) begin
                            tail_out[o]  = 1'b1;
                            gnt_vld_d[o] = 1'b0;
                        end
                    end
                end
            end else begin
                // Search starts one past the last winner, so it is served last.
                for (int k = 1; k <= NPORT; k++) begin
                    idx = SRCW'((int'(rr_q[o]) + k) % NPORT);
                    if (!gnt_vld_d[o] && nonempty[idx] && !busy[idx] &&
                        (ftype(front[idx]) == FT_HEAD) &&
                        (int'(front[idx][SRCW-1:0]) == o)) begin
                        gnt_vld_d[o] = 1'b1;
                        gnt_src_d[o] = idx;
                        rr_d[o]      = idx;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_vld_q <= '0;
            for (int i = 0; i < NPORT; i++) begin
                rd_ptr_q[i]  <= '0;
                wr_ptr_q[i]  <= '0;
                cnt_q[i]     <= '0;
                gnt_src_q[i] <= '0;
                rr_q[i]      <= '0;
                odata_q[i]   <= '0;
            end
        end else begin
            gnt_vld_q <= gnt_vld_d;
            for (int i = 0; i < NPORT; i++) begin
                gnt_src_q[i] <= gnt_src_d[i];
                rr_q[i]      <= rr_d[i];
                odata_q[i]   <= odata_d[i];
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTRW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTRW'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNTW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CNTW'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: FIFO storage is not reset; count and pointers alone define which
    // entries are valid, and a reset-free array can map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_flit[i];
        end
    end

`ifdef SW_PKTCNT_EN
    logic [15:0] pkt_cnt_q [NPORT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) pkt_cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (tail_out[o]) pkt_cnt_q[o] <= pkt_cnt_q[o] + 16'd1;
            end
        end
    end
`endif

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign bus.iready[g]                = (cnt_q[g] != CNTW'(DEPTH));
        assign bus.odata[g*FLITW +: FLITW]  = odata_q[g];
`ifdef SW_PKTCNT_EN
        assign bus.pkt_cnt[g*16 +: 16]      = pkt_cnt_q[g];
`endif
    end

endmodule

// File: tb/tb_sw_rr.sv
// ---------------------------------------------------------------------------
// tb_sw_rr -- self-checking bench for sw_rr (NPORT=4, FLITW=10, DEPTH=4).
// A queue-based reference model tracks packets per input and ownership per
// output and is compared against the DUT after every clock edge; directed
// scenarios additionally check hand-derived constants.
// Define SW_PKTCNT_EN on both RTL and bench to cover the packet counters.
// ---------------------------------------------------------------------------
module tb_sw_rr;
    localparam int NP = 4;
    localparam int FW = 10;
    localparam int DP = 4;

    typedef logic [FW-1:0]    flit_t;
    typedef logic [NP*FW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sw_rr_if #(.NPORT(NP), .FLITW(FW)) bus ();

    sw_rr #(.NPORT(NP), .FLITW(FW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    flit_t       mq    [NP][$];  // flits waiting at each input, oldest first
    int          m_own [NP];     // input owning each output, -1 if none
    int          m_ptr [NP];     // last input granted each output
    flit_t       m_out [NP];
    logic [15:0] m_pc  [NP];

    function automatic logic [1:0] ft(input flit_t f);
        return f[FW-1:FW-2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_own[i] = -1;
            m_ptr[i] = 0;
            m_out[i] = '0;
            m_pc[i]  = '0;
        end
    endtask

    function automatic logic [NP-1:0] model_iready();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = (mq[i].size() < DP);
        return r;
    endfunction

    function automatic vec_t model_odata();
        vec_t v;
        for (int o = 0; o < NP; o++) v[o*FW +: FW] = m_out[o];
        return v;
    endfunction

    // One clock edge of the switch as the behavioural rules describe it.
    task automatic model_step(input vec_t din);
        int    sz    [NP];
        bit    busy  [NP];
        int    newg  [NP];
        flit_t f;
        for (int i = 0; i < NP; i++) begin
            sz[i]   = mq[i].size();
            busy[i] = 0;
        end
        for (int o = 0; o < NP; o++) if (m_own[o] >= 0) busy[m_own[o]] = 1;
        // free outputs pick the first eligible head after their last winner
        for (int o = 0; o < NP; o++) begin
            newg[o] = -1;
            if (m_own[o] < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    int i = (m_ptr[o] + k) % NP;
                    if (newg[o] < 0 && !busy[i] && sz[i] > 0) begin
                        f = mq[i][0];
                        if (ft(f) == 2'b10 && int'(f[1:0]) == o) newg[o] = i;
                    end
                end
            end
        end
        // owned outputs move one flit; a tail frees the output
        for (int o = 0; o < NP; o++) begin
            m_out[o] = '0;
            if (m_own[o] >= 0 && sz[m_own[o]] > 0) begin
                f = mq[m_own[o]].pop_front();
                m_out[o] = f;
                if (ft(f) == 2'b11) begin
                    m_own[o] = -1;
                    m_pc[o]  = m_pc[o] + 16'd1;
                end
            end
        end
        // orphans and unroutable heads at free inputs are dropped
        for (int i = 0; i < NP; i++) begin
            if (!busy[i] && sz[i] > 0) begin
                f = mq[i][0];
                if (ft(f) != 2'b10 || int'(f[1:0]) >= NP) void'(mq[i].pop_front());
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (newg[o] >= 0) begin
                m_own[o] = newg[o];
                m_ptr[o] = newg[o];
            end
        end
        for (int i = 0; i < NP; i++) begin
            f = din[i*FW +: FW];
            if (ft(f) != 2'b00 && sz[i] < DP) mq[i].push_back(f);
        end
    endtask

    task automatic compare_all();
        check("odata", 64'(bus.odata), 64'(model_odata()));
        check("iready", 64'(bus.iready), 64'(model_iready()));
`ifdef SW_PKTCNT_EN
        for (int o = 0; o < NP; o++) check("pkt_cnt", 64'(bus.pkt_cnt[o*16 +: 16]), 64'(m_pc[o]));
`endif
    endtask

    // Drive one cycle of input, advance DUT and model, compare #1 after the edge.
    task automatic cycle(input vec_t din);
        bus.idata = din;
        @(posedge clk);
        model_step(din);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle('0);
    endtask

    task automatic pulse_reset();
        bus.idata = '0;
        rst = 1'b1;
        model_reset();
        #3;
        check("rst_odata", 64'(bus.odata), 64'(0));
        check("rst_iready", 64'(bus.iready), 64'(4'hF));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t put(input int port, input flit_t f);
        vec_t v;
        v = '0;
        v[port*FW +: FW] = f;
        return v;
    endfunction

    function automatic flit_t oflit(input int o);
        vec_t v;
        v = bus.odata;
        return v[o*FW +: FW];
    endfunction

    // ---------------- random traffic generator state ----------------
    int    rem      [NP];
    flit_t pend     [NP];
    bit    has_pend [NP];

    task automatic gen_clear();
        for (int i = 0; i < NP; i++) begin
            rem[i] = 0;
            has_pend[i] = 0;
        end
    endtask

    task automatic random_cycle(input bit allow_new);
        vec_t          din;
        logic [NP-1:0] rdy;
        din = '0;
        rdy = model_iready();
        for (int i = 0; i < NP; i++) begin
            if (!has_pend[i] && $urandom_range(0, 99) < 60 && (allow_new || rem[i] > 0)) begin
                if (rem[i] == 0) begin
                    if ($urandom_range(0, 99) < 10) begin
                        pend[i] = {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, 8'($urandom_range(0, 255))};
                    end else begin
                        pend[i] = {2'b10, 6'($urandom_range(0, 63)), 2'($urandom_range(0, NP-1))};
                        rem[i]  = $urandom_range(2, 5) - 1;
                    end
                end else if (rem[i] == 1) begin
                    pend[i] = {2'b11, 8'($urandom_range(0, 255))};
                    rem[i]  = 0;
                end else begin
                    pend[i] = {2'b01, 8'($urandom_range(0, 255))};
                    rem[i]  = rem[i] - 1;
                end
                has_pend[i] = 1;
            end
            if (has_pend[i]) begin
                if (rdy[i]) begin
                    din[i*FW +: FW] = pend[i];
                    has_pend[i] = 0;
                end else if ($urandom_range(0, 99) < 15) begin
                    din[i*FW +: FW] = pend[i];  // offered while full: lost, retried later
                end
            end
        end
        cycle(din);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int    seen [$];
        int    exp_ord [4];
        int    nflits;
        flit_t f;
        vec_t  ev;

        bus.idata = '0;
        model_reset();
        gen_clear();
        #2;
        pulse_reset();

        // Single packet i0 -> o1: head appears two edges after it is pushed.
        cycle(put(0, 10'b10_0000_0001));
        cycle(put(0, 10'b01_0101_0101));
        cycle(put(0, 10'b01_1010_1010));
        check("lat_head", 64'(oflit(1)), 64'(10'b10_0000_0001));
        check("lat_others", 64'({oflit(0), oflit(2), oflit(3)}), 64'(0));
        cycle(put(0, 10'b11_1001_0010));
        check("lat_body1", 64'(oflit(1)), 64'(10'b01_0101_0101));
        cycle('0);
        check("lat_body2", 64'(oflit(1)), 64'(10'b01_1010_1010));
        cycle('0);
        check("lat_tail", 64'(oflit(1)), 64'(10'b11_1001_0010));
        cycle('0);
        check("lat_after", 64'(oflit(1)), 64'(0));
        idle(2);

        // All four inputs send a 4-flit packet to o1 in the same cycles.
        exp_ord = '{1, 2, 3, 0};
        nflits = 0;
        for (int c = 0; c < 34; c++) begin
            ev = '0;
            for (int i = 0; i < NP; i++) begin
                case (c)
                    0:       ev[i*FW +: FW] = {2'b10, 4'(i), 4'b0001};
                    1, 2:    ev[i*FW +: FW] = {2'b01, 4'(i), 4'(c)};
                    3:       ev[i*FW +: FW] = {2'b11, 4'(i), 4'hF};
                    default: ev[i*FW +: FW] = '0;
                endcase
            end
            cycle(ev);
            f = oflit(1);
            if (f[9:8] == 2'b10) seen.push_back(int'(f[7:4]));
            if (f != '0) nflits++;
        end
        check("rr_count", 64'(seen.size()), 64'(4));
        for (int j = 0; j < seen.size() && j < 4; j++) check("rr_order", 64'(seen[j]), 64'(exp_ord[j]));
        check("rr_flits", 64'(nflits), 64'(16));

        // Disjoint pairs i0->o3, i1->o2, i2->o1, i3->o0 run concurrently.
        ev = '0;
        for (int i = 0; i < NP; i++) ev[i*FW +: FW] = {2'b10, 4'(i + 8), 2'b00, 2'(3 - i)};
        cycle(ev);
        ev = '0;
        for (int i = 0; i < NP; i++) ev[i*FW +: FW] = {2'b11, 4'(i), 4'h5};
        cycle(ev);
        cycle('0);
        for (int i = 0; i < NP; i++)
            check("pair_head", 64'(oflit(3 - i)), 64'({2'b10, 4'(i + 8), 2'b00, 2'(3 - i)}));
        idle(3);

        // Orphan tail with no head is discarded silently.
        cycle(put(2, 10'b11_0000_1111));
        for (int c = 0; c < 3; c++) begin
            cycle('0);
            check("orphan_odata", 64'(bus.odata), 64'(0));
        end
        check("orphan_iready", 64'(bus.iready), 64'(4'hF));

        // Reset after two flits of a packet, then a fresh packet goes through.
        cycle(put(0, 10'b10_0000_0001));
        cycle(put(0, 10'b01_0000_0000));
        pulse_reset();
        cycle(put(3, 10'b10_1100_0010));
        cycle(put(3, 10'b11_1100_0000));
        cycle('0);
        check("post_rst_head", 64'(oflit(2)), 64'(10'b10_1100_0010));
        check("post_rst_o1", 64'(oflit(1)), 64'(0));
        idle(3);

`ifdef SW_PKTCNT_EN
        pulse_reset();
        ev = '0;
        for (int i = 0; i < 3; i++) ev[i*FW +: FW] = {2'b10, 8'h00};
        ev[3*FW +: FW] = {2'b10, 8'h03};
        cycle(ev);
        ev = '0;
        for (int i = 0; i < NP; i++) ev[i*FW +: FW] = {2'b11, 8'h00};
        cycle(ev);
        idle(15);
        check("pktcnt_o0", 64'(bus.pkt_cnt[0 +: 16]), 64'(3));
        check("pktcnt_o3", 64'(bus.pkt_cnt[48 +: 16]), 64'(1));
`endif

        // Random traffic with a reset in the middle, then let packets finish.
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                pulse_reset();
                gen_clear();
            end
            random_cycle(1'b1);
        end
        for (int c = 0; c < 80; c++) random_cycle(1'b0);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
